// File: rtl/adpcmb_seq_if.sv
// adpcmb_seq ROM fetch port.
// Level request, one-cycle acknowledge with data.
interface adpcmb_seq_if;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ok;
  logic [7:0]  rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ok,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ok,
    output rom_data
  );
endinterface

// File: rtl/adpcmb_seq.sv
// ADPCM-B sample sequencer: ROM fetch, nibble split,
// delta-N pacing and adv spacing for the decoder pipe.
module adpcmb_seq #(
  parameter int ADV_GAP = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         start,
  input  logic         stop,
  input  logic [15:0]  start_addr,
  input  logic [15:0]  end_addr,
  input  logic [15:0]  delta_n,
  input  logic         repeat_en,
  input  logic         flag_clr,
  adpcmb_seq_if.master rom,
  output logic [3:0]   data,
  output logic         adv,
  output logic         clr,
  output logic         chon,
  output logic         eos,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(ADV_GAP - 1);

  state_t      state_q;
  state_t      state_n;

  logic [15:0] sa_q;
  logic [15:0] ea_q;
  logic        rep_q;
  logic [24:0] np_q;
  logic [15:0] acc_q;
  logic        tok_q;
  logic [3:0]  gap_q;
  logic        endp_q;

  logic [7:0]  cur_q;
  logic [7:0]  nxt_q;
  logic        cur_v_q;
  logic        nxt_v_q;
  logic [23:0] fptr_q;
  logic        fdone_q;
  logic        req_q;

  logic [7:0]  cur_n;
  logic [7:0]  nxt_n;
  logic        cur_vn;
  logic        nxt_vn;
  logic [23:0] fptr_n;
  logic        fdone_n;
  logic        req_n;

  logic [16:0] acc_sum;
  logic        carry_t;
  logic        issue;
  logic        last;
  logic        wrap;
  logic        finish;
  logic        flush;
  logic        take;
  logic [23:0] start_byte;
  logic [23:0] end_byte;

  assign rom.rom_req  = req_q;
  assign rom.rom_addr = fptr_q;
  assign chon         = (state_q != IDLE);

  assign start_byte = {sa_q, 8'h00};
  assign end_byte   = {ea_q, 8'hFF};

  assign acc_sum = {1'b0, acc_q} + {1'b0, delta_n};
  assign carry_t = cen && chon && acc_sum[16];

  assign issue = cen && (state_q == RUN)
              && tok_q && cur_v_q
              && (gap_q == 4'd0) && !endp_q
              && !start && !stop;

  assign last   = issue && (np_q == {ea_q, 9'h1FF});
  assign wrap   = last && rep_q;
  assign finish = cen && endp_q && (state_q == RUN);
  assign flush  = start || stop || wrap;
  assign take   = req_q && rom.rom_ok && !flush;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // next state: key-on/off first, then fill/run/end
  always_comb begin
    state_n = state_q;
    if (start) begin
      state_n = FILL;
    end else if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_n = IDLE;
        FILL: if (cur_vn) state_n = RUN;
        RUN: begin
          if (wrap)        state_n = FILL;
          else if (finish) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // byte buffers and fetch pointer next values
  always_comb begin
    cur_n   = cur_q;
    nxt_n   = nxt_q;
    cur_vn  = cur_v_q;
    nxt_vn  = nxt_v_q;
    fptr_n  = fptr_q;
    fdone_n = fdone_q;
    if (issue && np_q[0]) begin
      cur_n  = nxt_q;
      cur_vn = nxt_v_q;
      nxt_vn = 1'b0;
    end
    if (take) begin
      if (!cur_vn) begin
        cur_n  = rom.rom_data;
        cur_vn = 1'b1;
      end else begin
        nxt_n  = rom.rom_data;
        nxt_vn = 1'b1;
      end
      if (fptr_q == end_byte) begin
        if (rep_q) fptr_n = start_byte;
        else       fdone_n = 1'b1;
      end else begin
        fptr_n = fptr_q + 24'd1;
      end
    end
    if (flush) begin
      cur_vn  = 1'b0;
      nxt_vn  = 1'b0;
      fdone_n = 1'b0;
      fptr_n  = start ? {start_addr, 8'h00}
                      : start_byte;
    end
  end

  // request drops for a cycle on flush so the
  // address never moves under a live request
  assign req_n = (state_n != IDLE) && !fdone_n
              && !(cur_vn && nxt_vn) && !flush;

  // fetch engine registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= 8'h00;
      nxt_q   <= 8'h00;
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
      fptr_q  <= 24'h0;
      fdone_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      cur_q   <= cur_n;
      nxt_q   <= nxt_n;
      cur_v_q <= cur_vn;
      nxt_v_q <= nxt_vn;
      fptr_q  <= fptr_n;
      fdone_q <= fdone_n;
      req_q   <= req_n;
    end
  end

  // channel parameters latched on key-on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 16'h0;
      ea_q  <= 16'h0;
      rep_q <= 1'b0;
    end else if (start) begin
      sa_q  <= start_addr;
      ea_q  <= end_addr;
      rep_q <= repeat_en;
    end
  end

  // nibble pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     np_q <= 25'h0;
    else if (start) np_q <= {start_addr, 9'h0};
    else if (wrap)  np_q <= {sa_q, 9'h0};
    else if (issue) np_q <= np_q + 25'd1;
  end

  // phase accumulator, pending token, gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 16'h0;
      tok_q <= 1'b0;
      gap_q <= 4'd0;
    end else if (start) begin
      acc_q <= 16'h0;
      tok_q <= 1'b0;
      gap_q <= 4'd0;
    end else if (cen) begin
      if (chon) acc_q <= acc_sum[15:0];
      tok_q <= (tok_q && !issue) || carry_t;
      if (issue)               gap_q <= GAP_LD;
      else if (gap_q != 4'd0)  gap_q <= gap_q - 4'd1;
    end
  end

  // end-of-sample pending: leave RUN on the next cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 endp_q <= 1'b0;
    else if (start || stop)     endp_q <= 1'b0;
    else if (last && !rep_q)    endp_q <= 1'b1;
    else if (finish)            endp_q <= 1'b0;
  end

  // decoder outputs, registered on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv  <= 1'b0;
      data <= 4'h0;
    end else if (start || stop) begin
      adv  <= 1'b0;
    end else if (cen) begin
      adv <= issue;
      if (issue) data <= np_q[0] ? cur_q[3:0]
                                 : cur_q[7:4];
    end
  end

  // decoder clear, one clk after key-on or loop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr <= 1'b0;
    else        clr <= start || wrap;
  end

  // sticky flags; setting beats clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eos     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (last)          eos <= 1'b1;
      else if (flag_clr) eos <= 1'b0;
      if (carry_t && tok_q && !issue) overrun <= 1'b1;
      else if (flag_clr)              overrun <= 1'b0;
    end
  end

endmodule

// File: doc/adpcmb_seq.md
# adpcmb_seq

Sequencer that drives the ADPCM-B decoder datapath: it walks a sample from a start to an end address in ROM, fetches bytes through a request/acknowledge port, and splits them into nibbles, high nibble first. A 16-bit delta-N phase accumulator sets the sample rate, and the block paces `adv` pulses so that no pulse enters the decoder's 5-stage pipeline before the previous one has retired. It sits between the channel register file and the decoder, and supplies that decoder's `data`, `adv`, `clr` and `chon` inputs.

## Interface
- `ADV_GAP`, default 6: minimum number of `cen` periods between consecutive `adv` pulses. Legal values are 5 to 15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cen`  in  1  clock enable, shared with the decoder.
- `start`  in  1  key-on, one `clk` pulse; latches `start_addr`, `end_addr` and `repeat_en`.
- `stop`  in  1  key-off, one `clk` pulse.
- `start_addr`  in  16  first byte = `{start_addr, 8'h00}`.
- `end_addr`  in  16  last byte, inclusive = `{end_addr, 8'hFF}`.
- `delta_n`  in  16  phase step; used live on every `cen`.
- `repeat_en`  in  1  loop back to start on reaching end.
- `flag_clr`  in  1  clears `eos`.
- `rom_req`  out  1  fetch request, held as a level.
- `rom_addr`  out  24  byte address; stable while `rom_req` is high.
- `rom_ok`  in  1  one-cycle acknowledge; `rom_data` is valid in the same cycle.
- `rom_data`  in  8  fetched byte.
- `data`  out  4  nibble to the decoder.
- `adv`  out  1  decoder advance.
- `clr`  out  1  decoder clear, one `clk` pulse.
- `chon`  out  1  channel on.
- `eos`  out  1  sticky end-of-sample flag.
- `overrun`  out  1  sticky flag: a phase carry was dropped. Cleared by `flag_clr`.

## Operation
- **State machine:**
  - IDLE.
  - FILL: waiting for the first byte.
  - RUN.
- **Reset:**
  - All outputs are 0.
  - `rom_addr` = 0.
  - Accumulator = 0.
  - Both byte buffers are invalid.
  - State = IDLE.
- **On `start`, from any state:**
  - Latch the inputs.
  - Nibble pointer `np` (25 bits) = `{start_addr, 9'h0}`.
  - Accumulator = 0, pending token = 0, gap counter = 0.
  - Flush both buffers; drop any outstanding request.
  - `clr` = 1 for one `clk`; `chon` = 1.
  - Go to FILL.
  - `start` wins over `stop` in the same cycle.
- **On `stop`:**
  - Go to IDLE; `chon` = 0.
  - Drop `rom_req`. A `rom_ok` arriving afterwards is ignored.
  - `eos` is not set.
- **Fetch engine:**
  - Two byte buffers, `cur` and `nxt`.
  - While `chon` is high and either buffer is free, assert `rom_req` with `rom_addr` = the fetch pointer.
  - On `rom_ok`, fill `cur` if it is empty, otherwise `nxt`, then increment the fetch pointer.
  - The fetch pointer wraps from 0xFFFFFF to 0. It stops at the end byte; in repeat mode it then reloads to `{start_addr, 8'h00}`.
  - FILL becomes RUN when `cur` becomes valid.
- **Phase accumulator:**
  - On each `cen` while `chon` is high: `{carry, acc}` = `acc + delta_n`.
  - A carry sets the pending token.
  - A carry while the token is already set sets `overrun`; that carry is dropped.
- **Issue, on a `cen` in RUN:**
  - Conditions: the token is set, `cur` is valid, and the gap counter has reached 0.
  - `adv` = 1.
  - `data` = `cur[7:4]` if `np[0]` = 0, otherwise `cur[3:0]`.
  - Clear the token; gap counter = `ADV_GAP` − 1, decremented on each `cen`.
  - `np` increments, wrapping over 25 bits.
  - After a low nibble: `cur` ← `nxt`, and `nxt` becomes invalid.
- **Underrun:** if the token is set but `cur` is invalid, the token waits. The sample is delayed, not lost.
- **End of sample:** when the nibble issued is the low nibble of byte `{end_addr, 8'hFF}`:
  - `eos` is set.
  - If `repeat_en`: `np` reloads to the start, both buffers flush, `clr` pulses on the next `clk`, and the state goes to FILL.
  - Otherwise: on the next `cen` the state goes to IDLE and `chon` = 0.
- **`eos` priority:** if `eos` is set and `flag_clr` is asserted in the same cycle, the set wins.
- **`end_addr` < `start_addr`:** playback runs through the 24-bit wrap to reach the end.

## Timing
- `adv` and `data` are registered and update only on `cen` cycles:
  - The decoder samples them on the following `cen`.
  - `adv` is high for exactly one `cen` period.
- In IDLE and FILL, `adv` = 0 and `data` holds its last value.
- `clr` is exactly one `clk` wide, one cycle after `start` or after a repeat wrap.
- Latency from a carry to `adv` is 1 `cen`, when the data is ready and the gap has expired.
- With `delta_n` = 0xFFFF, carries arrive on every `cen`; `adv` spacing is then exactly `ADV_GAP`, and `overrun` sets.
- `rom_addr` changes only in a cycle where `rom_req` is low or `rom_ok` is high.
- `rst_n` asserted mid-fetch: `rom_req` falls asynchronously.

## Test plan
- **Basic playback:** `start_addr` = 0x0001, `end_addr` = 0x0001, `delta_n` = 0x1000, ROM byte n = n[7:0].
  - First fetch is at 0x000100.
  - Nibbles issued: 0,0,0,1,0,2,…,F,F.
  - 512 `adv` pulses in total, one every 16 `cen`.
  - `eos` = 1 and `chon` = 0 after the last.
- **Repeat:** same setup with `repeat_en` = 1.
  - After nibble 512, `clr` pulses once and the next fetch is at 0x000100.
  - `chon` stays 1.
  - `eos` sets and is cleared by `flag_clr`.
- **Rate cap:** `delta_n` = 0xFFFF, `ADV_GAP` = 6.
  - Consecutive `adv` pulses are exactly 6 `cen` apart.
  - `overrun` = 1.
- **Slow ROM:** `rom_ok` arrives 20 `clk` after each request, with `cen` every 4 `clk` and `delta_n` = 0x8000.
  - No nibble is skipped or duplicated; the issue order matches ROM content.
- **Stop mid-fetch:** assert `stop` while `rom_req` is high; a late `rom_ok` follows.
  - `rom_req` drops the next cycle.
  - The late `rom_ok` is ignored.
  - `chon` = 0, `eos` = 0.
- **Wrap:** `start_addr` = 0xFFFF, `end_addr` = 0x0000.
  - Fetch addresses run 0xFFFF00…0xFFFFFF, then 0x000000…0x0000FF.
  - `eos` is set after 1024 nibbles.
